// File: rtl/dbg_ctrl_pkg.sv
// ============================================================================
// Module   : dbg_ctrl_pkg
// Brief    : Shared op codes, FSM states and address-map constants for dbg_ctrl
// Revision : 1.0
// ============================================================================
`default_nettype none

package dbg_ctrl_pkg;

   localparam int unsigned MEM_WORDS    = 1024;
   localparam int unsigned REG_BASE     = 1024;
   localparam int unsigned REG_WORDS    = 32;
   localparam int unsigned HALT_TIMEOUT = 16;

   localparam logic [2:0] OP_NOP   = 3'd0;
   localparam logic [2:0] OP_READ  = 3'd1;
   localparam logic [2:0] OP_WRITE = 3'd2;
   localparam logic [2:0] OP_HALT  = 3'd3;
   localparam logic [2:0] OP_RUN   = 3'd4;
   localparam logic [2:0] OP_STEP  = 3'd5;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_ACCESS   = 3'd1,
      ST_RDWAIT   = 3'd2,
      ST_STEP     = 3'd3,
      ST_HALTWAIT = 3'd4,
      ST_RESP     = 3'd5
   } state_t;

   function automatic logic op_legal(input logic [2:0] op);
      return op <= OP_STEP;
   endfunction

endpackage

`default_nettype wire

// File: rtl/dbg_ctrl_if.sv
// ============================================================================
// Module   : dbg_ctrl_if
// Brief    : Host command/response channel plus CPU debug port signals
// Revision : 1.0
// ============================================================================
`default_nettype none

interface dbg_ctrl_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [2:0]  cmd_op;
   logic [31:0] cmd_addr;
   logic [31:0] cmd_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_data;
   logic        rsp_err;
   logic        dbg_enable;
   logic        dbg_rd_wr;
   logic [31:0] dbg_address;
   logic [31:0] dbg_data_out;
   logic [31:0] dbg_data_in;
   logic        dbg_step;
   logic        dbg_run;
   logic        dbg_halt;

   modport slave (
      input  cmd_valid, cmd_op, cmd_addr, cmd_wdata, rsp_ready, dbg_data_in, dbg_halt,
      output cmd_ready, rsp_valid, rsp_data, rsp_err,
      output dbg_enable, dbg_rd_wr, dbg_address, dbg_data_out, dbg_step, dbg_run
   );

   modport master (
      output cmd_valid, cmd_op, cmd_addr, cmd_wdata, rsp_ready, dbg_data_in, dbg_halt,
      input  cmd_ready, rsp_valid, rsp_data, rsp_err,
      input  dbg_enable, dbg_rd_wr, dbg_address, dbg_data_out, dbg_step, dbg_run
   );
endinterface

`default_nettype wire

// File: rtl/dbg_addr_decode.sv
// ============================================================================
// Module   : dbg_addr_decode
// Brief    : Combinational memory / register window check for a word address
// Revision : 1.0
// ============================================================================
`default_nettype none

module dbg_addr_decode #(
   parameter int unsigned MEM_WORDS = dbg_ctrl_pkg::MEM_WORDS,
   parameter int unsigned REG_BASE  = dbg_ctrl_pkg::REG_BASE,
   parameter int unsigned REG_WORDS = dbg_ctrl_pkg::REG_WORDS
) (
   input  logic [31:0] addr,
   output logic        is_mem,
   output logic        is_reg,
   output logic        addr_ok
);
   // 33-bit bounds so the register window end cannot wrap past 2^32
   localparam logic [32:0] MEM_END = 33'(MEM_WORDS);
   localparam logic [32:0] REG_LO  = 33'(REG_BASE);
   localparam logic [32:0] REG_HI  = 33'(REG_BASE) + 33'(REG_WORDS);

   logic [32:0] w_addr;

   assign w_addr  = {1'b0, addr};
   assign is_mem  = w_addr < MEM_END;
   assign is_reg  = (w_addr >= REG_LO) && (w_addr < REG_HI);
   assign addr_ok = is_mem | is_reg;
endmodule

`default_nettype wire

// File: rtl/dbg_ctrl.sv
// ============================================================================
// Module   : dbg_ctrl
// Brief    : Host-command sequencer driving the CPU debug port, one response per command
// Revision : 1.0
// ============================================================================
`default_nettype none

module dbg_ctrl #(
   parameter int unsigned MEM_WORDS    = dbg_ctrl_pkg::MEM_WORDS,
   parameter int unsigned REG_BASE     = dbg_ctrl_pkg::REG_BASE,
   parameter int unsigned REG_WORDS    = dbg_ctrl_pkg::REG_WORDS,
   parameter int unsigned HALT_TIMEOUT = dbg_ctrl_pkg::HALT_TIMEOUT
) (
   input  logic        clk,
   input  logic        reset,
   dbg_ctrl_if.slave   bus
);
   import dbg_ctrl_pkg::*;

   localparam int CNT_W = $clog2(HALT_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALT_TIMEOUT - 1);

   state_t           r_state;
   logic [CNT_W-1:0] r_halt_cnt;
   logic             w_is_mem;
   logic             w_is_reg;
   logic             w_addr_ok;
   logic             w_is_access;
   logic             w_needs_halt;
   logic             w_reject;

   dbg_addr_decode #(
      .MEM_WORDS (MEM_WORDS),
      .REG_BASE  (REG_BASE),
      .REG_WORDS (REG_WORDS)
   ) u_addr_decode (
      .addr    (bus.cmd_addr),
      .is_mem  (w_is_mem),
      .is_reg  (w_is_reg),
      .addr_ok (w_addr_ok)
   );

   assign w_is_access  = (bus.cmd_op == OP_READ) || (bus.cmd_op == OP_WRITE);
   assign w_needs_halt = w_is_access || (bus.cmd_op == OP_STEP);
   assign w_reject     = !op_legal(bus.cmd_op)
                       || (w_needs_halt && !bus.dbg_halt)
                       || (w_is_access && !w_addr_ok);

   assign bus.cmd_ready = (r_state == ST_IDLE) && !reset;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state          <= ST_IDLE;
         r_halt_cnt       <= '0;
         bus.rsp_valid    <= 1'b0;
         bus.rsp_err      <= 1'b0;
         bus.rsp_data     <= '0;
         bus.dbg_enable   <= 1'b0;
         bus.dbg_rd_wr    <= 1'b0;
         bus.dbg_address  <= '0;
         bus.dbg_data_out <= '0;
         bus.dbg_step     <= 1'b0;
         bus.dbg_run      <= 1'b0;
      end else begin
         bus.dbg_enable <= 1'b0;
         bus.dbg_step   <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (bus.cmd_valid) begin
                  bus.rsp_data <= '0;
                  bus.rsp_err  <= 1'b0;
                  if (w_reject) begin
                     bus.rsp_err   <= 1'b1;
                     bus.rsp_valid <= 1'b1;
                     r_state       <= ST_RESP;
                  end else begin
                     case (bus.cmd_op)
                        OP_READ, OP_WRITE: begin
                           bus.dbg_enable   <= 1'b1;
                           bus.dbg_rd_wr    <= (bus.cmd_op == OP_WRITE);
                           bus.dbg_address  <= bus.cmd_addr;
                           bus.dbg_data_out <= bus.cmd_wdata;
                           r_state          <= ST_ACCESS;
                        end
                        OP_STEP: begin
                           bus.dbg_step <= 1'b1;
                           r_state      <= ST_STEP;
                        end
                        OP_RUN: begin
                           bus.dbg_run   <= 1'b1;
                           bus.rsp_valid <= 1'b1;
                           r_state       <= ST_RESP;
                        end
                        OP_HALT: begin
                           bus.dbg_run <= 1'b0;
                           r_halt_cnt  <= '0;
                           r_state     <= ST_HALTWAIT;
                        end
                        default: begin
                           bus.rsp_valid <= 1'b1;
                           r_state       <= ST_RESP;
                        end
                     endcase
                  end
               end
            end
            ST_ACCESS: begin
               if (bus.dbg_rd_wr) begin
                  bus.rsp_valid <= 1'b1;
                  r_state       <= ST_RESP;
               end else begin
                  r_state <= ST_RDWAIT;
               end
            end
            ST_RDWAIT: begin
               bus.rsp_data  <= bus.dbg_data_in;
               bus.rsp_valid <= 1'b1;
               r_state       <= ST_RESP;
            end
            ST_STEP: begin
               bus.rsp_valid <= 1'b1;
               r_state       <= ST_RESP;
            end
            ST_HALTWAIT: begin
               // halt status wins over a timeout landing on the same cycle
               if (bus.dbg_halt) begin
                  bus.rsp_valid <= 1'b1;
                  r_state       <= ST_RESP;
               end else if (r_halt_cnt == CNT_LAST) begin
                  bus.rsp_err   <= 1'b1;
                  bus.rsp_valid <= 1'b1;
                  r_state       <= ST_RESP;
               end else begin
                  r_halt_cnt <= r_halt_cnt + 1'b1;
               end
            end
            ST_RESP: begin
               if (bus.rsp_ready) begin
                  bus.rsp_valid <= 1'b0;
                  r_state       <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end
endmodule

`default_nettype wire

// File: tb/tb_dbg_ctrl.sv
// ============================================================================
// Module   : tb_dbg_ctrl
// Brief    : Scoreboard bench for dbg_ctrl with CPU/memory model and random commands
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_dbg_ctrl;
   import dbg_ctrl_pkg::*;

   typedef struct {
      logic [31:0] data;
      logic        err;
      logic        run;
      int          lat;
   } rsp_exp_t;

   typedef struct {
      logic [31:0] addr;
      logic        wr;
      logic [31:0] data;
   } acc_exp_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   dbg_ctrl_if bus();

   dbg_ctrl #(
      .MEM_WORDS    (1024),
      .REG_BASE     (1024),
      .REG_WORDS    (32),
      .HALT_TIMEOUT (16)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   rsp_exp_t    rsp_q[$];
   acc_exp_t    acc_q[$];
   logic [31:0] ref_mem  [logic [31:0]];
   logic [31:0] port_mem [logic [31:0]];
   int n_cmp = 0, n_bad = 0;
   int cyc = 0, hs_cyc = 0, rsp_lat = 0, rsp_done = 0;
   int steps_exp = 0, steps_seen = 0, stall = 0;
   logic m_halted = 1'b0, m_run = 1'b0;

   function automatic logic [31:0] dflt(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // debug-port memory: registered read data available the cycle after the strobe
   always @(posedge clk) begin
      if (bus.dbg_enable) begin
         if (bus.dbg_rd_wr) port_mem[bus.dbg_address] = bus.dbg_data_out;
         else bus.dbg_data_in <= port_mem.exists(bus.dbg_address) ?
                                 port_mem[bus.dbg_address] : dflt(bus.dbg_address);
      end
   end

   always @(posedge clk) begin
      #1;
      if (bus.rsp_valid && stall > 0) begin
         bus.rsp_ready = 1'b0;
         stall--;
      end else begin
         bus.rsp_ready = ($urandom_range(0, 3) != 0);
      end
   end

   logic        prev_valid = 1'b0, prev_ready = 1'b0, prev_err = 1'b0;
   logic [31:0] prev_data = '0;

   always @(negedge clk) begin
      rsp_exp_t e;
      acc_exp_t a;
      if (reset) begin
         prev_valid = 1'b0;
      end else begin
         if (bus.cmd_valid && bus.cmd_ready) hs_cyc = cyc;
         if (bus.rsp_valid && !prev_valid) rsp_lat = cyc - hs_cyc;
         if (bus.rsp_valid && prev_valid && !prev_ready) begin
            check("rsp_data_stable", bus.rsp_data, prev_data);
            check("rsp_err_stable", 32'(bus.rsp_err), 32'(prev_err));
            check("cmd_ready_in_resp", 32'(bus.cmd_ready), 32'd0);
         end
         if (bus.rsp_valid && bus.rsp_ready) begin
            if (rsp_q.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL rsp_unexpected: got response data %h err %0d expected none",
                        bus.rsp_data, bus.rsp_err);
            end else begin
               e = rsp_q.pop_front();
               check("rsp_data", bus.rsp_data, e.data);
               check("rsp_err", 32'(bus.rsp_err), 32'(e.err));
               check("dbg_run_at_rsp", 32'(bus.dbg_run), 32'(e.run));
               check("rsp_latency", 32'(rsp_lat), 32'(e.lat));
            end
            rsp_done++;
         end
         if (bus.dbg_enable) begin
            if (acc_q.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL port_unexpected: got enable addr %h expected none", bus.dbg_address);
            end else begin
               a = acc_q.pop_front();
               check("dbg_address", bus.dbg_address, a.addr);
               check("dbg_rd_wr", 32'(bus.dbg_rd_wr), 32'(a.wr));
               check("dbg_data_out", bus.dbg_data_out, a.data);
               check("enable_latency", 32'(cyc - hs_cyc), 32'd1);
            end
         end
         if (bus.dbg_step) begin
            steps_seen++;
            check("step_latency", 32'(cyc - hs_cyc), 32'd1);
         end
         prev_valid = bus.rsp_valid;
         prev_ready = bus.rsp_ready;
         prev_data  = bus.rsp_data;
         prev_err   = bus.rsp_err;
      end
   end

   // hdelay: cycles after the handshake until the CPU reports halted; 0 = never
   task automatic issue(input logic [2:0] op, input logic [31:0] addr,
                        input logic [31:0] wd, input int hdelay);
      rsp_exp_t e;
      acc_exp_t a;
      logic in_range, halt_pending;
      int target, b;
      longint la;
      la = longint'(addr);
      in_range = (la < 1024) || (la >= 1024 && la < 1024 + 32);
      halt_pending = 1'b0;
      e.data = '0; e.err = 1'b0; e.lat = 1;
      if (op > OP_STEP) e.err = 1'b1;
      else if ((op == OP_READ || op == OP_WRITE || op == OP_STEP) && !m_halted) e.err = 1'b1;
      else if ((op == OP_READ || op == OP_WRITE) && !in_range) e.err = 1'b1;
      else begin
         case (op)
            OP_READ: begin
               e.data = ref_mem.exists(addr) ? ref_mem[addr] : dflt(addr);
               e.lat = 3;
               a.addr = addr; a.wr = 1'b0; a.data = wd;
               acc_q.push_back(a);
            end
            OP_WRITE: begin
               ref_mem[addr] = wd;
               e.lat = 2;
               a.addr = addr; a.wr = 1'b1; a.data = wd;
               acc_q.push_back(a);
            end
            OP_STEP: begin
               e.lat = 2;
               steps_exp++;
            end
            OP_RUN: m_run = 1'b1;
            OP_HALT: begin
               m_run = 1'b0;
               if (m_halted) e.lat = 2;
               else if (hdelay == 0) begin
                  e.lat = HALT_TIMEOUT + 1;
                  e.err = 1'b1;
               end else begin
                  e.lat = hdelay + 1;
                  halt_pending = 1'b1;
               end
            end
            default: e.lat = 1;
         endcase
      end
      e.run = m_run;
      rsp_q.push_back(e);
      target = rsp_done + 1;

      @(posedge clk); #1;
      bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_addr = addr; bus.cmd_wdata = wd;
      b = 0;
      while (!bus.cmd_ready && b < 50) begin
         @(posedge clk); #1;
         b++;
      end
      if (b == 50) begin
         n_cmp++; n_bad++;
         $display("FAIL cmd_accept_timeout: got cmd_ready 0 expected 1 within 50 cycles");
      end
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0;
      bus.cmd_op = 3'($urandom); bus.cmd_addr = $urandom; bus.cmd_wdata = $urandom;
      if (halt_pending) begin
         repeat (hdelay - 1) begin
            @(posedge clk); #1;
         end
         bus.dbg_halt = 1'b1;
         m_halted = 1'b1;
      end
      b = 0;
      while (rsp_done < target && b < 200) begin
         @(negedge clk);
         b++;
      end
      if (rsp_done < target) begin
         n_cmp++; n_bad++;
         $display("FAIL rsp_timeout: got no response expected one within 200 cycles (op %0d)", op);
      end
      if (op == OP_RUN && !e.err) begin
         @(posedge clk); #1;
         bus.dbg_halt = 1'b0;
         m_halted = 1'b0;
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
      check({tag, "_rsp_err"}, 32'(bus.rsp_err), 32'd0);
      check({tag, "_rsp_data"}, bus.rsp_data, 32'd0);
      check({tag, "_dbg_enable"}, 32'(bus.dbg_enable), 32'd0);
      check({tag, "_dbg_rd_wr"}, 32'(bus.dbg_rd_wr), 32'd0);
      check({tag, "_dbg_address"}, bus.dbg_address, 32'd0);
      check({tag, "_dbg_data_out"}, bus.dbg_data_out, 32'd0);
      check({tag, "_dbg_step"}, 32'(bus.dbg_step), 32'd0);
      check({tag, "_dbg_run"}, 32'(bus.dbg_run), 32'd0);
      check({tag, "_cmd_ready"}, 32'(bus.cmd_ready), 32'd0);
   endtask

   function automatic logic [31:0] pick_addr();
      case ($urandom_range(0, 5))
         0: return 32'($urandom_range(0, 1023));
         1: return 32'(1024 + $urandom_range(0, 31));
         2: case ($urandom_range(0, 3))
               0: return 32'h3FF;
               1: return 32'h400;
               2: return 32'h41F;
               default: return 32'h420;
            endcase
         3: return $urandom;
         4: return 32'hFFFF_FFFF;
         default: return 32'h10;
      endcase
   endfunction

   initial begin
      reset = 1'b1;
      bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_addr = '0; bus.cmd_wdata = '0;
      bus.dbg_halt = 1'b0; bus.dbg_data_in = '0; bus.rsp_ready = 1'b0;
      @(negedge clk);
      check_all_zero("reset");
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      check("cmd_ready_after_reset", 32'(bus.cmd_ready), 32'd1);

      issue(OP_HALT, 32'h0, 32'h0, 3);
      issue(OP_WRITE, 32'h10, 32'hDEAD_BEEF, 0);
      issue(OP_READ, 32'h10, 32'h1234_5678, 0);
      issue(OP_READ, 32'h41F, 32'h0, 0);
      issue(OP_READ, 32'h420, 32'h0, 0);
      issue(OP_READ, 32'hFFFF_FFFF, 32'h0, 0);
      issue(OP_WRITE, 32'h400, 32'hCAFE_F00D, 0);
      issue(OP_READ, 32'h3FF, 32'h0, 0);
      issue(OP_STEP, 32'h0, 32'h0, 0);
      issue(OP_RUN, 32'h0, 32'h0, 0);
      issue(OP_RUN, 32'h0, 32'h0, 0);
      issue(OP_READ, 32'h0, 32'h0, 0);
      issue(OP_STEP, 32'h0, 32'h0, 0);
      issue(3'd6, 32'h0, 32'h0, 0);
      issue(3'd7, 32'h0, 32'h0, 0);
      issue(OP_NOP, 32'h0, 32'h0, 0);
      issue(OP_HALT, 32'h0, 32'h0, 0);
      issue(OP_HALT, 32'h0, 32'h0, 2);
      issue(OP_HALT, 32'h0, 32'h0, 0);
      stall = 5;
      issue(OP_READ, 32'h10, 32'h0, 0);

      // reset while the READ strobe is on the port: no access, no response
      @(posedge clk); #1;
      bus.cmd_valid = 1'b1; bus.cmd_op = OP_READ; bus.cmd_addr = 32'h20; bus.cmd_wdata = 32'h5;
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      check_all_zero("abort");
      @(posedge clk); #1;
      reset = 1'b0;
      m_run = 1'b0;
      @(negedge clk);
      check("cmd_ready_after_abort", 32'(bus.cmd_ready), 32'd1);
      repeat (6) @(negedge clk);

      for (int i = 0; i < 80; i++) begin
         issue(3'($urandom_range(0, 7)), pick_addr(), $urandom, $urandom_range(0, 6));
      end

      repeat (4) @(negedge clk);
      check("step_count", 32'(steps_seen), 32'(steps_exp));
      check("rsp_q_empty", 32'(rsp_q.size()), 32'd0);
      check("acc_q_empty", 32'(acc_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no end of test expected finish before 500000");
      $fatal(1, "watchdog expired");
   end
endmodule

`default_nettype wire
